// File: rtl/videocard_pkg.sv
// Shared definitions for the videocard host port and the videocard itself.
package videocard_pkg;

  // Mailbox layout agreed with the videocard firmware.
  localparam logic [31:0] MAILBOX_BASE_DEFAULT = 32'h0000_0040;
  localparam logic [31:0] STATUS_ADDR_DEFAULT  = 32'h0000_003F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE_DATA,
    ST_WRITE_LEN,
    ST_CLEAR_STATUS,
    ST_KICK,
    ST_WAIT,
    ST_READ_ISSUE,
    ST_READ_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/videocard_cmd_buffer.sv
// Register-file command buffer: words are pushed in order, then read back
// in the same order through a separate read index.
module videocard_cmd_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic [IW-1:0]    rd_idx,
  output logic [IW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;

  // Index and occupancy bookkeeping; clear rewinds for the next packet.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + 1'b1;
        count  <= count + 1'b1;
      end
      if (pop) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Word storage, no reset needed since count qualifies the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/videocard_host_port.sv
// Host-side initiator: buffers a command packet, copies it into the shared
// RAM mailbox, kicks the videocard and polls the status word for completion.
module videocard_host_port
  import videocard_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 16,
  parameter logic [WIDTH-1:0] MAILBOX_BASE   = WIDTH'(MAILBOX_BASE_DEFAULT),
  parameter logic [WIDTH-1:0] STATUS_ADDR    = WIDTH'(STATUS_ADDR_DEFAULT),
  parameter int               POLL_INTERVAL  = 8,
  parameter int               TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_word,
  input  logic             cmd_last,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] data_out,
  output logic             wren,
  input  logic [WIDTH-1:0] data_in,
  output logic             bus_own,
  output logic             interrupt_start,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] status
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(POLL_INTERVAL + 1);

  localparam logic [WIDTH-1:0] DATA_BASE = MAILBOX_BASE + WIDTH'(1);
  localparam logic [CW-1:0]    FULL_AT   = CW'(DEPTH - 1);
  localparam logic [TW-1:0]    T_LIMIT   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0]    P_LIMIT   = PW'(POLL_INTERVAL - 1);

  state_t           state, state_next;
  logic             cmd_ready_next, wren_next, bus_own_next;
  logic             interrupt_start_next, done_next, error_next;
  logic [WIDTH-1:0] address_next, data_next, status_next;
  logic [TW-1:0]    tcount, tcount_next;
  logic [PW-1:0]    pcount, pcount_next;
  logic             handshake, expire;
  logic             push, pop, clear;
  logic [WIDTH-1:0] rd_data;
  logic [IW-1:0]    rd_idx;
  logic [CW-1:0]    count;

  videocard_cmd_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cmd_word),
    .pop       (pop),
    .clear     (clear),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .count     (count)
  );

  // Next state and next registered outputs; the outputs for a state are
  // computed on the way into it so that every port comes from a flop.
  always_comb begin
    state_next           = state;
    cmd_ready_next       = 1'b0;
    wren_next            = 1'b0;
    bus_own_next         = 1'b0;
    interrupt_start_next = 1'b0;
    done_next            = 1'b0;
    error_next           = 1'b0;
    address_next         = address;
    data_next            = data_out;
    status_next          = status;
    tcount_next          = tcount;
    pcount_next          = pcount;
    push                 = 1'b0;
    pop                  = 1'b0;
    clear                = 1'b0;
    handshake            = cmd_valid && cmd_ready;
    expire               = (tcount == T_LIMIT);

    case (state)
      ST_IDLE: begin
        cmd_ready_next = 1'b1;
        if (handshake) begin
          push        = 1'b1;
          status_next = '0;
          if (cmd_last) begin
            // Single-word packet: the word bypasses the buffer into data_out.
            state_next     = ST_WRITE_DATA;
            cmd_ready_next = 1'b0;
            bus_own_next   = 1'b1;
            wren_next      = 1'b1;
            address_next   = DATA_BASE;
            data_next      = cmd_word;
            pop            = 1'b1;
          end else begin
            state_next = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        cmd_ready_next = 1'b1;
        if (handshake) begin
          push = 1'b1;
          if (cmd_last || count == FULL_AT) begin
            state_next     = ST_WRITE_DATA;
            cmd_ready_next = 1'b0;
            bus_own_next   = 1'b1;
            wren_next      = 1'b1;
            address_next   = DATA_BASE;
            data_next      = rd_data;
            pop            = 1'b1;
          end
        end
      end

      ST_WRITE_DATA: begin
        bus_own_next = 1'b1;
        wren_next    = 1'b1;
        // A full buffer wraps both indices to zero, so equality means all sent.
        if (rd_idx != count[IW-1:0]) begin
          address_next = DATA_BASE + WIDTH'(rd_idx);
          data_next    = rd_data;
          pop          = 1'b1;
        end else begin
          state_next   = ST_WRITE_LEN;
          address_next = MAILBOX_BASE;
          data_next    = WIDTH'(count);
        end
      end

      ST_WRITE_LEN: begin
        state_next   = ST_CLEAR_STATUS;
        bus_own_next = 1'b1;
        wren_next    = 1'b1;
        address_next = STATUS_ADDR;
        data_next    = '0;
      end

      ST_CLEAR_STATUS: begin
        state_next           = ST_KICK;
        interrupt_start_next = 1'b1;
        tcount_next          = '0;
      end

      ST_KICK: begin
        tcount_next = tcount + 1'b1;
        if (expire) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          error_next  = 1'b1;
          status_next = '0;
        end else begin
          state_next  = ST_WAIT;
          pcount_next = '0;
        end
      end

      ST_WAIT: begin
        tcount_next = tcount + 1'b1;
        if (expire) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          error_next  = 1'b1;
          status_next = '0;
        end else if (pcount == P_LIMIT) begin
          state_next   = ST_READ_ISSUE;
          bus_own_next = 1'b1;
          address_next = STATUS_ADDR;
        end else begin
          pcount_next = pcount + 1'b1;
        end
      end

      ST_READ_ISSUE: begin
        tcount_next = tcount + 1'b1;
        if (expire) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          error_next  = 1'b1;
          status_next = '0;
        end else begin
          state_next   = ST_READ_CHECK;
          bus_own_next = 1'b1;
        end
      end

      ST_READ_CHECK: begin
        tcount_next = tcount + 1'b1;
        // A completion seen in the expiry cycle still counts as success.
        if (data_in != '0) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          status_next = data_in;
        end else if (expire) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          error_next  = 1'b1;
          status_next = '0;
        end else begin
          state_next  = ST_WAIT;
          pcount_next = '0;
        end
      end

      ST_DONE: begin
        state_next     = ST_IDLE;
        cmd_ready_next = 1'b1;
        clear          = 1'b1;
      end

      default: begin
        state_next     = ST_IDLE;
        cmd_ready_next = 1'b1;
        clear          = 1'b1;
      end
    endcase
  end

  // State, counters and all output registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cmd_ready       <= 1'b1;
      wren            <= 1'b0;
      bus_own         <= 1'b0;
      interrupt_start <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      status          <= '0;
      address         <= '0;
      data_out        <= '0;
      tcount          <= '0;
      pcount          <= '0;
    end else begin
      state           <= state_next;
      cmd_ready       <= cmd_ready_next;
      wren            <= wren_next;
      bus_own         <= bus_own_next;
      interrupt_start <= interrupt_start_next;
      done            <= done_next;
      error           <= error_next;
      status          <= status_next;
      address         <= address_next;
      data_out        <= data_next;
      tcount          <= tcount_next;
      pcount          <= pcount_next;
    end
  end

endmodule

// File: tb/tb_videocard_host_port.sv
// Bench for videocard_host_port: RAM model with a videocard responder port,
// and a scoreboard of expected RAM writes and completion results.
module tb_videocard_host_port;

  localparam logic [31:0] MB = 32'h0000_0040;
  localparam logic [31:0] SA = 32'h0000_003F;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic        err;
    logic [31:0] st;
  } done_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        cmd_last;
  logic        cmd_ready;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        wren;
  logic [31:0] data_in;
  logic        bus_own;
  logic        interrupt_start;
  logic        done;
  logic        error;
  logic [31:0] status;

  logic        resp_we;
  logic [7:0]  resp_addr;
  logic [31:0] resp_data;
  logic [31:0] ram [256];

  int checks = 0;
  int errors = 0;

  wr_t         exp_writes[$];
  done_t       exp_done[$];
  logic [31:0] pkt[$];

  videocard_host_port #(
    .WIDTH          (32),
    .DEPTH          (16),
    .MAILBOX_BASE   (MB),
    .STATUS_ADDR    (SA),
    .POLL_INTERVAL  (7),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_word        (cmd_word),
    .cmd_last        (cmd_last),
    .cmd_ready       (cmd_ready),
    .address         (address),
    .data_out        (data_out),
    .wren            (wren),
    .data_in         (data_in),
    .bus_own         (bus_own),
    .interrupt_start (interrupt_start),
    .done            (done),
    .error           (error),
    .status          (status)
  );

  always #5 clk = ~clk;

  // Shared single-port RAM behind the bus mux; q is one clock behind address.
  always @(posedge clk) begin
    if (bus_own) begin
      if (wren) ram[address[7:0]] <= data_out;
      data_in <= ram[address[7:0]];
    end else begin
      if (resp_we) ram[resp_addr] <= resp_data;
      data_in <= ram[resp_addr];
    end
  end

  task automatic ram_poke(input logic [7:0] a, input logic [31:0] d);
    resp_we = 1'b1; resp_addr = a; resp_data = d;
    @(negedge clk);
    resp_we = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    bit ok = 0;
    int waited = 0;
    cmd_valid = 1'b1; cmd_word = w; cmd_last = last;
    while (!ok && waited < 50) begin
      if (cmd_ready === 1'b1) ok = 1;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL handshake: word %h not accepted within %0d cycles", w, waited);
    end
  endtask

  // Drives pkt word by word; optionally queues the expected mailbox writes.
  task automatic send_packet(input logic use_last, input bit expect_writes);
    int n = pkt.size();
    if (expect_writes) begin
      for (int k = 0; k < n; k++) exp_writes.push_back('{addr: MB + 32'(k) + 32'd1, data: pkt[k]});
      exp_writes.push_back('{addr: MB, data: 32'(n)});
      exp_writes.push_back('{addr: SA, data: 32'h0});
    end
    for (int k = 0; k < n; k++) send_word(pkt[k], use_last && (k == n - 1));
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  // Cycle loop starting the cycle after the last handshake: pops the
  // scoreboard on every RAM write and on done, runs the responder.
  task automatic run_packet(input int resp_offset, input logic [31:0] resp_val,
                            input int hold_cycles, input int exp_kick, input int exp_done_rel);
    int i = 0;
    int kick_at = -1;
    int done_at = -1;
    int kicks = 0;
    int dones = 0;
    wr_t   w;
    done_t d;
    while (i < 400) begin
      if (i < hold_cycles) begin
        cmd_word = 32'h111 + 32'(i / 2);
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL hold_ready: cycle %0d cmd_ready=%b required 0", i, cmd_ready);
        end
      end else if (i == hold_cycles && hold_cycles > 0) begin
        cmd_valid = 1'b0;
      end
      if (bus_own === 1'b1 && wren === 1'b1) begin
        checks++;
        if (exp_writes.size() == 0) begin
          errors++;
          $display("[TB] FAIL ram_write: unexpected write addr %h data %h", address, data_out);
        end else begin
          w = exp_writes.pop_front();
          if (address !== w.addr || data_out !== w.data) begin
            errors++;
            $display("[TB] FAIL ram_write: got addr %h data %h required addr %h data %h",
                     address, data_out, w.addr, w.data);
          end
        end
      end
      if (interrupt_start === 1'b1) begin
        kicks++;
        kick_at = i;
      end
      if (kick_at >= 0 && resp_offset >= 0 && i == kick_at + resp_offset) begin
        checks++;
        if (bus_own !== 1'b0) begin
          errors++;
          $display("[TB] FAIL resp_bus: bus_own=%b during responder write, required 0", bus_own);
        end
        resp_we = 1'b1; resp_addr = SA[7:0]; resp_data = resp_val;
      end else begin
        resp_we = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = i;
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("[TB] FAIL done_result: unexpected done error=%b status=%h", error, status);
        end else begin
          d = exp_done.pop_front();
          if (error !== d.err || status !== d.st) begin
            errors++;
            $display("[TB] FAIL done_result: got error=%b status=%h required error=%b status=%h",
                     error, status, d.err, d.st);
          end
        end
      end
      if (done_at >= 0 && i >= done_at + 10) break;
      @(negedge clk);
      i++;
    end
    resp_we = 1'b0;
    checks++;
    if (kicks != 1 || kick_at != exp_kick) begin
      errors++;
      $display("[TB] FAIL kick: got %0d pulses at cycle %0d required 1 at cycle %0d", kicks, kick_at, exp_kick);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL done_count: got %0d done pulses required 1", dones);
    end
    if (exp_done_rel >= 0) begin
      checks++;
      if (done_at - kick_at != exp_done_rel) begin
        errors++;
        $display("[TB] FAIL done_latency: got %0d cycles after kick required %0d", done_at - kick_at, exp_done_rel);
      end
    end
    checks++;
    if (exp_writes.size() != 0) begin
      errors++;
      $display("[TB] FAIL writes_left: %0d expected writes never seen, required 0", exp_writes.size());
      exp_writes.delete();
    end
    exp_done.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
    if (wren !== 1'b0) begin errors++; $display("[TB] FAIL rst_wren: got %b required 0", wren); end
    if (bus_own !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_own: got %b required 0", bus_own); end
    if (interrupt_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq: got %b required 0", interrupt_start); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b required 0", done); end
    if (error !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: got %b required 0", error); end
    if (status !== 32'h0) begin errors++; $display("[TB] FAIL rst_status: got %h required 0", status); end
    if (address !== 32'h0) begin errors++; $display("[TB] FAIL rst_address: got %h required 0", address); end
    if (data_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_data_out: got %h required 0", data_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_three_words();
    pkt = '{32'd11, 32'd22, 32'd33};
    exp_done.push_back('{err: 1'b0, st: 32'hA5});
    send_packet(1'b1, 1'b1);
    run_packet(50, 32'hA5, 0, 5, -1);
    checks++;
    if (ram[8'h41] !== 32'd11 || ram[8'h42] !== 32'd22 || ram[8'h43] !== 32'd33 || ram[8'h40] !== 32'd3) begin
      errors++;
      $display("[TB] FAIL three_ram: got %h %h %h len %h required 0b 16 21 len 3",
               ram[8'h41], ram[8'h42], ram[8'h43], ram[8'h40]);
    end
    checks++;
    if (status !== 32'hA5) begin
      errors++;
      $display("[TB] FAIL status_hold: got %h required a5", status);
    end
  endtask

  task automatic test_timeout();
    pkt = '{32'h77};
    exp_done.push_back('{err: 1'b1, st: 32'h0});
    send_packet(1'b1, 1'b1);
    run_packet(-1, 32'h0, 0, 3, 64);
  endtask

  task automatic test_truncate();
    ram_poke(8'h51, 32'h0BAD_0051);
    pkt.delete();
    for (int k = 1; k <= 16; k++) pkt.push_back(32'h100 + 32'(k));
    exp_done.push_back('{err: 1'b1, st: 32'h0});
    send_packet(1'b0, 1'b1);
    cmd_valid = 1'b1; cmd_word = 32'h111; cmd_last = 1'b0;
    run_packet(-1, 32'h0, 8, 18, 64);
    checks++;
    if (ram[8'h40] !== 32'd16 || ram[8'h50] !== 32'h110 || ram[8'h51] !== 32'h0BAD_0051) begin
      errors++;
      $display("[TB] FAIL trunc_ram: got len %h last %h next %h required 10 110 0bad0051",
               ram[8'h40], ram[8'h50], ram[8'h51]);
    end
  endtask

  task automatic test_same_cycle();
    pkt = '{32'h88};
    exp_done.push_back('{err: 1'b0, st: 32'h5A});
    send_packet(1'b1, 1'b1);
    run_packet(58, 32'h5A, 0, 3, 64);
  endtask

  task automatic test_reset_abort();
    int irqs = 0;
    int dones = 0;
    int writes = 0;
    ram_poke(8'h40, 32'hBAD0);
    ram_poke(8'h43, 32'hBAD3);
    pkt = '{32'h71, 32'h72, 32'h73};
    send_packet(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (wren !== 1'b1 || address !== 32'h42) begin
      errors++;
      $display("[TB] FAIL abort_pos: got wren=%b addr=%h required 1 and 42", wren, address);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wren !== 1'b0 || bus_own !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got wren=%b bus_own=%b cmd_ready=%b required 0 0 1",
               wren, bus_own, cmd_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (interrupt_start === 1'b1) irqs++;
      if (done === 1'b1) dones++;
      if (wren === 1'b1) writes++;
      @(negedge clk);
    end
    checks++;
    if (irqs != 0 || dones != 0 || writes != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got irq=%0d done=%0d writes=%0d required all 0", irqs, dones, writes);
    end
    checks++;
    if (ram[8'h40] !== 32'hBAD0 || ram[8'h43] !== 32'hBAD3) begin
      errors++;
      $display("[TB] FAIL abort_ram: got len %h word3 %h required bad0 bad3", ram[8'h40], ram[8'h43]);
    end
  endtask

  task automatic test_back_to_back();
    pkt = '{32'h99};
    exp_done.push_back('{err: 1'b0, st: 32'h1234});
    send_packet(1'b1, 1'b1);
    run_packet(20, 32'h1234, 0, 3, -1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_word = '0; cmd_last = 1'b0;
    resp_we = 1'b0; resp_addr = '0; resp_data = '0;
    @(negedge clk);
    test_reset();
    test_three_words();
    test_timeout();
    test_truncate();
    test_same_cycle();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
